// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: selects next PC (sequential, branch, J/JAL, JR/JALR, exception),
// holds on stall and buffers one redirect that arrives while stalled.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        j_take,
  input  logic [25:0] j_index,
  input  logic [31:0] pc_base,
  input  logic        jr_take,
  input  logic [31:0] jr_target,
  input  logic        exc_take,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redir,
  output logic        pend,
  output logic        adel
);

  typedef enum logic {RUN, PEND} state_t;

  // Priority class of a redirect request; a larger value wins.
  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_BR   = 2'd1;
  localparam logic [1:0] CLS_J    = 2'd2;
  localparam logic [1:0] CLS_JR   = 2'd3;

  state_t      state, state_n;
  logic [31:0] pend_tgt, pend_tgt_n;
  logic [1:0]  pend_cls, pend_cls_n;
  logic [31:0] pc_n;
  logic        redir_n, adel_n;

  logic [1:0]  req_cls;
  logic [31:0] req_tgt;
  logic        load_en;
  logic [31:0] load_tgt;
  logic        misaligned;

  // Only the region bits of pc_base take part in the J target.
  logic unused_pc_base_bits;
  assign unused_pc_base_bits = ^pc_base[27:0];

  // NOTE: every variable written in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    req_cls = CLS_NONE;
    req_tgt = '0;
    if (jr_take) begin
      req_cls = CLS_JR;
      req_tgt = jr_target;
    end else if (j_take) begin
      req_cls = CLS_J;
      req_tgt = {pc_base[31:28], j_index, 2'b00};
    end else if (br_take) begin
      req_cls = CLS_BR;
      req_tgt = br_target;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed by the combinational blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      pend_tgt <= '0;
      pend_cls <= CLS_NONE;
      redir    <= 1'b0;
      adel     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      pend_tgt <= pend_tgt_n;
      pend_cls <= pend_cls_n;
      redir    <= redir_n;
      adel     <= adel_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_tgt_n = pend_tgt;
    pend_cls_n = pend_cls;
    redir_n    = 1'b0;
    adel_n     = 1'b0;
    load_en    = 1'b0;
    load_tgt   = '0;

    if (exc_take) begin
      pc_n       = EXC_VEC;
      redir_n    = 1'b1;
      state_n    = RUN;
      pend_tgt_n = '0;
      pend_cls_n = CLS_NONE;
    end else begin
      unique case (state)
        RUN: begin
          if (!stall) begin
            if (req_cls != CLS_NONE) begin
              load_en  = 1'b1;
              load_tgt = req_tgt;
            end else begin
              pc_n = pc_plus4;
            end
          end else if (req_cls != CLS_NONE) begin
            pend_tgt_n = req_tgt;
            pend_cls_n = req_cls;
            state_n    = PEND;
          end
        end
        PEND: begin
          if (stall) begin
            if (req_cls > pend_cls) begin
              pend_tgt_n = req_tgt;
              pend_cls_n = req_cls;
            end
          end else begin
            // The buffered redirect owns the delay slot; same-cycle requests are dropped.
            load_en    = 1'b1;
            load_tgt   = pend_tgt;
            state_n    = RUN;
            pend_tgt_n = '0;
            pend_cls_n = CLS_NONE;
          end
        end
        default: state_n = RUN;
      endcase
    end

    if (load_en) begin
      redir_n = 1'b1;
      if (misaligned) begin
        pc_n       = EXC_VEC;
        adel_n     = 1'b1;
        state_n    = RUN;
        pend_tgt_n = '0;
        pend_cls_n = CLS_NONE;
      end else begin
        pc_n = load_tgt;
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = load_tgt[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    pc_plus4 = pc + 32'd4;
    pend     = (state == PEND);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected post-edge state is queued per step and
// compared one cycle later with immediate assertions.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_take;
  logic [31:0] br_target;
  logic        j_take;
  logic [25:0] j_index;
  logic [31:0] pc_base;
  logic        jr_take;
  logic [31:0] jr_target;
  logic        exc_take;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redir;
  logic        pend;
  logic        adel;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        redir;
    logic        pend;
    logic        adel;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_take   (br_take),
    .br_target (br_target),
    .j_take    (j_take),
    .j_index   (j_index),
    .pc_base   (pc_base),
    .jr_take   (jr_take),
    .jr_target (jr_target),
    .exc_take  (exc_take),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .redir     (redir),
    .pend      (pend),
    .adel      (adel)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    stall     = 1'b0;
    br_take   = 1'b0;
    br_target = '0;
    j_take    = 1'b0;
    j_index   = '0;
    pc_base   = '0;
    jr_take   = 1'b0;
    jr_target = '0;
    exc_take  = 1'b0;
  endtask

  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s.%s got %h want %h", tag, field, obs, exp);
    end
  endtask

  // Queue the expectation, apply one edge, then compare against the oldest entry.
  task automatic tick(input string tag, input logic [31:0] epc,
                      input logic er, input logic ep, input logic ea);
    exp_t e;
    exp_t got;
    e.tag = tag; e.pc = epc; e.redir = er; e.pend = ep; e.adel = ea;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk(got.tag, "pc",       pc,           got.pc);
    chk(got.tag, "pc_plus4", pc_plus4,     got.pc + 32'd4);
    chk(got.tag, "redir",    {31'd0, redir}, {31'd0, got.redir});
    chk(got.tag, "pend",     {31'd0, pend},  {31'd0, got.pend});
    chk(got.tag, "adel",     {31'd0, adel},  {31'd0, got.adel});
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick("reset0", 32'h0000_3000, 0, 0, 0);
    tick("reset1", 32'h0000_3000, 0, 0, 0);
    reset = 1'b0;

    // free run
    tick("seq1", 32'h0000_3004, 0, 0, 0);
    tick("seq2", 32'h0000_3008, 0, 0, 0);
    tick("seq3", 32'h0000_300C, 0, 0, 0);

    // J target built from pc_base region and index
    j_take = 1'b1; pc_base = 32'h9000_3010; j_index = 26'h0000_C40;
    tick("j", 32'h9000_3100, 1, 0, 0);
    idle();
    tick("j_after", 32'h9000_3104, 0, 0, 0);

    // jr beats br in the same cycle
    br_take = 1'b1; br_target = 32'h0000_3040;
    jr_take = 1'b1; jr_target = 32'h0000_3080;
    tick("jr_over_br", 32'h0000_3080, 1, 0, 0);

    // stalled redirects: higher-priority jr replaces buffered br
    idle(); stall = 1'b1; br_take = 1'b1; br_target = 32'h0000_3200;
    tick("stall_br", 32'h0000_3080, 0, 1, 0);
    idle(); stall = 1'b1; jr_take = 1'b1; jr_target = 32'h0000_3300;
    tick("stall_jr", 32'h0000_3080, 0, 1, 0);
    idle(); stall = 1'b1;
    tick("stall_hold", 32'h0000_3080, 0, 1, 0);
    idle();
    tick("release", 32'h0000_3300, 1, 0, 0);
    tick("release_next", 32'h0000_3304, 0, 0, 0);

    // lower-priority request while pending is ignored; release ignores same-cycle request
    stall = 1'b1; jr_take = 1'b1; jr_target = 32'h0000_3400;
    tick("pend_jr", 32'h0000_3304, 0, 1, 0);
    idle(); stall = 1'b1; br_take = 1'b1; br_target = 32'h0000_3500;
    tick("pend_br_low", 32'h0000_3304, 0, 1, 0);
    idle(); j_take = 1'b1; pc_base = 32'h0000_3000; j_index = 26'h0000_F00;
    tick("release_drop_j", 32'h0000_3400, 1, 0, 0);
    idle();
    tick("release_drop_next", 32'h0000_3404, 0, 0, 0);

    // exception while pending and stalled
    stall = 1'b1; br_take = 1'b1; br_target = 32'h0000_3200;
    tick("pend_for_exc", 32'h0000_3404, 0, 1, 0);
    idle(); stall = 1'b1; exc_take = 1'b1;
    tick("exc_stalled", 32'h0000_4180, 1, 0, 0);
    idle(); stall = 1'b1;
    tick("exc_hold", 32'h0000_4180, 0, 0, 0);
    idle();
    tick("exc_release", 32'h0000_4184, 0, 0, 0);

    // exception beats jr in RUN
    exc_take = 1'b1; jr_take = 1'b1; jr_target = 32'h0000_3700;
    tick("exc_over_jr", 32'h0000_4180, 1, 0, 0);

    // wrap-around of sequential increment
    idle(); jr_take = 1'b1; jr_target = 32'hFFFF_FFFC;
    tick("jr_top", 32'hFFFF_FFFC, 1, 0, 0);
    idle();
    tick("wrap", 32'h0000_0000, 0, 0, 0);

    // misaligned jr target
    jr_take = 1'b1; jr_target = 32'h0000_3002;
`ifdef PC_ALIGN_CHECK_EN
    tick("misalign", 32'h0000_4180, 1, 0, 1);
    idle();
    tick("misalign_next", 32'h0000_4184, 0, 0, 0);
`else
    tick("misalign", 32'h0000_3002, 1, 0, 0);
    idle();
    tick("misalign_next", 32'h0000_3006, 0, 0, 0);
`endif

    // reset mid-operation discards the buffer and overrides requests
    stall = 1'b1; br_take = 1'b1; br_target = 32'h0000_3600;
    tick("pend_for_reset", (`ifdef PC_ALIGN_CHECK_EN 32'h0000_4184 `else 32'h0000_3006 `endif), 0, 1, 0);
    idle(); reset = 1'b1; jr_take = 1'b1; jr_target = 32'h0000_3800;
    tick("reset_mid", 32'h0000_3000, 0, 0, 0);
    idle(); reset = 1'b0;
    tick("after_reset", 32'h0000_3004, 0, 0, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
